fixed_div_unit: RTL
===================

FIXED_DIV_UNIT -- requirements
Module: fixed_div_unit

Interface
REQ-001 SHALL have parameter NUM_W, default 16, dividend width in bits.
REQ-002 SHALL have parameter DEN_W, default 16, divisor width in bits.
REQ-003 SHALL have parameter FRAC_W, default 16, fractional bits appended below the dividend (quotient scale 2^FRAC_W).
REQ-004 SHALL have parameter Q_W, default 16, result width in bits.
REQ-005 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port Start  input  1  request to launch one division.
REQ-008 SHALL have port Num  input  NUM_W  unsigned dividend.
REQ-009 SHALL have port Den  input  DEN_W  unsigned divisor.
REQ-010 SHALL have port Quot  output  Q_W  result, valid while Ack=1.
REQ-011 SHALL have port Ack  output  1  operation complete; Quot and flags valid.
REQ-012 SHALL have port Busy  output  1  high in every state except IDLE and DONE.
REQ-013 SHALL have port DivZero  output  1  Den was 0.
REQ-014 SHALL have port Ovf  output  1  true quotient exceeded 2^Q_W-1.

Function
REQ-015 SHALL compute Quot = min(floor(Num*2^FRAC_W/Den), 2^Q_W-1), unsigned.
REQ-016 SHALL use an FSM with states IDLE, CALC, ROUND (present only with the macro), and DONE.
REQ-017 SHALL sample Start only in IDLE or DONE, latching Num and Den on that edge; Start in CALC or ROUND SHALL be ignored.
REQ-018 SHALL, for Den != 0, perform one restoring-division step per CALC cycle, MSB first, over ITER = NUM_W+FRAC_W extended-dividend bits, with a remainder register DEN_W+1 bits wide.
REQ-019 SHALL assert Ack exactly ITER+1 cycles after the Start-sampling edge (ITER+2 with the macro).
REQ-020 SHALL, for Den == 0, skip CALC and enter DONE on the next edge with Quot all ones, DivZero=1 and Ovf=0.
REQ-021 SHALL set Ovf=1 and Quot all ones when any computed quotient bit at or above position Q_W is set.
REQ-022 SHALL hold Ack, Quot, DivZero and Ovf stable in DONE until Start is sampled; that edge SHALL clear Ack and flags and enter CALC directly (or DONE for Den==0).
REQ-023 SHALL return from DONE to IDLE only via reset.

Reset
REQ-024 SHALL, when Reset=0 at a rising edge, enter IDLE and clear Quot, Ack, Busy, DivZero, Ovf, the iteration counter and the remainder, including mid-operation.
REQ-025 SHALL give Reset priority over a simultaneous Start.

Configuration
REQ-026 SHALL honour macro FIXED_DIV_ROUND_EN: when defined, one extra guard-bit iteration SHALL be followed by a ROUND cycle adding the guard bit (half-LSB upward rounding), saturating to all ones with Ovf=1 on carry-out; when undefined, the quotient SHALL be truncated and no ROUND state SHALL exist.

Structure
REQ-027 SHALL import the FSM state enum and the ITER-width helper function from package fixed_div_pkg.
REQ-028 SHALL instantiate one combinational sub-module, fixed_div_step, which takes the remainder, the incoming bit and Den and returns the next remainder and the quotient bit.

Verification
REQ-029 SHALL cover: defaults, Num=1, Den=4 -> Quot=0x4000, Ack 33 cycles after the Start edge, Ovf=0.
REQ-030 SHALL cover: Num=1, Den=6 -> Quot=0x2AAA without the macro and 0x2AAB with it; Num=1, Den=36 -> 0x071C in both builds.
REQ-031 SHALL cover: Den=0, Num=5 -> Quot=0xFFFF, DivZero=1, Ack on the next edge.
REQ-032 SHALL cover: Num=2, Den=1 -> Quot=0xFFFF, Ovf=1.
REQ-033 SHALL cover: Reset=0 in the 10th CALC cycle -> next edge Busy=0, Ack=0, Quot=0, and a new Start then yields a correct result.
REQ-034 SHALL cover: Start pulsed in CALC -> ignored; back-to-back Start in DONE with Num=1, Den=3 -> Quot=0x5555.

Source files
------------

// File: rtl/fixed_div_pkg.sv
// ---------------------------------------------------------------------------
// fixed_div_pkg
// Shared types and helpers for the fixed-point divider.
//   div_state_e     : FSM state encoding (ST_ROUND only exists when
//                     FIXED_DIV_ROUND_EN is defined).
//   iter_cnt_width  : width of a counter that must hold 0..iter inclusive.
// Configuration macro: FIXED_DIV_ROUND_EN (adds the rounding state).
// ---------------------------------------------------------------------------
package fixed_div_pkg;

`ifdef FIXED_DIV_ROUND_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ROUND = 2'd3
    } div_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DONE  = 2'd2
    } div_state_e;
`endif

    // Counter width able to represent every value from 0 to iter.
    function automatic int iter_cnt_width(input int iter);
        int w;
        w = $clog2(iter + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fixed_div_step.sv
// ---------------------------------------------------------------------------
// fixed_div_step
// One combinational restoring-division step: shift the incoming dividend
// bit into the partial remainder and subtract the divisor if it fits.
//   rem_i  [DEN_W:0]   : current partial remainder (always < den_i)
//   bit_i              : next extended-dividend bit, MSB first
//   den_i  [DEN_W-1:0] : divisor (non-zero)
//   rem_o  [DEN_W:0]   : next partial remainder
//   q_o                : quotient bit produced by this step
// ---------------------------------------------------------------------------
module fixed_div_step #(
    parameter int DEN_W = 16
) (
    input  logic [DEN_W:0]   rem_i,
    input  logic             bit_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [DEN_W:0]   rem_o,
    output logic             q_o
);

    logic [DEN_W+1:0] shifted;
    logic [DEN_W+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {2'b00, den_i};
        // shifted < 2*den, so the top bit of the difference is a clean borrow.
        q_o     = ~diff[DEN_W+1];
        rem_o   = q_o ? diff[DEN_W:0] : shifted[DEN_W:0];
    end

endmodule

// File: rtl/fixed_div_unit.sv
// ---------------------------------------------------------------------------
// fixed_div_unit
// Sequential unsigned fixed-point divider:
//   Quot = min(floor(Num * 2^FRAC_W / Den), 2^Q_W - 1)
// One restoring step per CALC cycle, MSB first.
// Ports:
//   Clk     : clock, rising edge
//   Reset   : synchronous, active-low reset (priority over Start)
//   Start   : launch request, sampled only in IDLE or DONE
//   Num     : unsigned dividend (NUM_W bits)
//   Den     : unsigned divisor  (DEN_W bits)
//   Quot    : result (Q_W bits), valid while Ack=1
//   Ack     : result and flags valid, held in DONE
//   Busy    : high while calculating (CALC/ROUND)
//   DivZero : Den was zero
//   Ovf     : true quotient did not fit in Q_W bits (Quot saturated)
// Configuration macro: FIXED_DIV_ROUND_EN -- adds a guard-bit iteration and a
// ROUND cycle that rounds half-LSB upward; otherwise the result is truncated.
// ---------------------------------------------------------------------------
module fixed_div_unit
    import fixed_div_pkg::*;
#(
    parameter int NUM_W  = 16,
    parameter int DEN_W  = 16,
    parameter int FRAC_W = 16,
    parameter int Q_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [NUM_W-1:0] Num,
    input  logic [DEN_W-1:0] Den,
    output logic [Q_W-1:0]   Quot,
    output logic             Ack,
    output logic             Busy,
    output logic             DivZero,
    output logic             Ovf
);

`ifdef FIXED_DIV_ROUND_EN
    localparam int GUARD_W = 1;
`else
    localparam int GUARD_W = 0;
`endif
    // Number of division steps (extended dividend bits, plus guard bit).
    localparam int ITER  = NUM_W + FRAC_W + GUARD_W;
    // Quotient accumulator keeps Q_W result bits plus the guard bit.
    localparam int QA_W  = Q_W + GUARD_W;
    localparam int CNT_W = iter_cnt_width(ITER);
    // Without rounding, CALC spends one extra cycle (cnt == ITER) publishing
    // the result; with rounding, the last step hands over to ROUND instead.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - GUARD_W);

    div_state_e       state_q, state_d;
    logic [ITER-1:0]  ext_q, ext_d;        // extended dividend, shifted out MSB first
    logic [DEN_W:0]   rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [QA_W-1:0]  qacc_q, qacc_d;
    logic             qovf_q, qovf_d;      // a quotient bit >= 2^Q_W was produced
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [Q_W-1:0]   quot_q, quot_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;

    logic             step_en;
    logic [DEN_W:0]   step_rem;
    logic             step_bit;

    fixed_div_step #(
        .DEN_W (DEN_W)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (ext_q[ITER-1]),
        .den_i (den_q),
        .rem_o (step_rem),
        .q_o   (step_bit)
    );

`ifdef FIXED_DIV_ROUND_EN
    logic [Q_W:0] round_sum;
    assign round_sum = {1'b0, qacc_q[QA_W-1:1]} + {{Q_W{1'b0}}, qacc_q[0]};
`endif

    always_comb begin
        state_d    = state_q;
        ext_d      = ext_q;
        rem_d      = rem_q;
        den_d      = den_q;
        qacc_d     = qacc_q;
        qovf_d     = qovf_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        step_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    ack_d  = 1'b0;
                    ovf_d  = 1'b0;
                    quot_d = '0;
                    if (Den == '0) begin
                        state_d    = ST_DONE;
                        quot_d     = '1;
                        div_zero_d = 1'b1;
                        ack_d      = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        state_d    = ST_CALC;
                        div_zero_d = 1'b0;
                        busy_d     = 1'b1;
                        ext_d      = ITER'(Num) << (FRAC_W + GUARD_W);
                        den_d      = Den;
                        rem_d      = '0;
                        qacc_d     = '0;
                        qovf_d     = 1'b0;
                        cnt_d      = '0;
                    end
                end
            end

            ST_CALC: begin
`ifdef FIXED_DIV_ROUND_EN
                step_en = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_ROUND;
                end
`else
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    quot_d  = qovf_q ? '1 : qacc_q;
                    ovf_d   = qovf_q;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    step_en = 1'b1;
                end
`endif
            end

`ifdef FIXED_DIV_ROUND_EN
            ST_ROUND: begin
                // Guard bit adds half an LSB; carry out of Q_W bits saturates.
                state_d = ST_DONE;
                ack_d   = 1'b1;
                busy_d  = 1'b0;
                if (qovf_q || round_sum[Q_W]) begin
                    quot_d = '1;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = round_sum[Q_W-1:0];
                    ovf_d  = 1'b0;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (step_en) begin
            rem_d  = step_rem;
            ext_d  = ext_q << 1;
            // Bit leaving the accumulator top sits at weight >= 2^Q_W.
            qovf_d = qovf_q | qacc_q[QA_W-1];
            qacc_d = (qacc_q << 1) | QA_W'(step_bit);
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            ext_q      <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            qacc_q     <= '0;
            qovf_q     <= 1'b0;
            cnt_q      <= '0;
            quot_q     <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ext_q      <= ext_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            qacc_q     <= qacc_d;
            qovf_q     <= qovf_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Quot    = quot_q;
    assign Ack     = ack_q;
    assign Busy    = busy_q;
    assign DivZero = div_zero_q;
    assign Ovf     = ovf_q;

endmodule
